// File: rtl/cam_vip_seq_ctrl.sv
// Camera VIP timing sequencer: vsync/href framing, pixel pointers
// and round-robin frame-buffer select from a runtime config.
module cam_vip_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int PTR_W   = 16,
  parameter int MAX_BUF = 4
) (
  input  logic                         cam_clk_o,
  input  logic                         s_rstn,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic [PTR_W-1:0]             cfg_hres_i,
  input  logic [PTR_W-1:0]             cfg_vres_i,
  input  logic [PTR_W-1:0]             cfg_hblank_i,
  input  logic [7:0]                   cfg_vsync_lines_i,
  input  logic [7:0]                   cfg_vbp_lines_i,
  input  logic [7:0]                   cfg_vfp_lines_i,
  input  logic [15:0]                  cfg_nframes_i,
  input  logic [$clog2(MAX_BUF):0]     cfg_nbuf_i,
  output logic                         busy_o,
  output logic                         vsync_o,
  output logic                         href_o,
  output logic                         bytesel_o,
  output logic [PTR_W-1:0]             col_o,
  output logic [PTR_W-1:0]             line_o,
  output logic [CNT_W-1:0]             pix_addr_o,
  output logic [$clog2(MAX_BUF)-1:0]   bufsel_o,
  output logic                         frame_done_o,
  output logic                         seq_done_o,
  output logic                         err_o
);

  localparam int BUF_W = $clog2(MAX_BUF);
  localparam int NB_W  = BUF_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
  } st_t;

  st_t              state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;

  logic [PTR_W-1:0] sh_hres, sh_vres, sh_hblank;
  logic [7:0]       sh_vs, sh_vbp, sh_vfp;
  logic [15:0]      sh_nfr;
  logic [NB_W-1:0]  sh_nbuf;
  logic             stop_q;
  logic [15:0]      frm_q;

  logic             idle, cfg_ok, go, bad;
  logic [PTR_W-1:0] u_hres, u_hblank;
  logic [7:0]       u_vs, vs_n;
  logic [CNT_W-1:0] lp, vs_len, vbp_len, vfp_len, act_len;
  logic             tmr_last, line_last, col_last, vfp_end, end_seq;
  logic [15:0]      fr_next;
  logic [NB_W-1:0]  nb_inc;

  logic             busy_d, vsync_d, href_d, bsel_d;
  logic [PTR_W-1:0] col_d, line_d;
  logic [CNT_W-1:0] addr_d;
  logic [BUF_W-1:0] buf_d;
  logic             fdone_d, sdone_d, err_d;

  assign idle   = (state_q == S_IDLE);
  assign cfg_ok = (cfg_hres_i != '0) && (cfg_vres_i != '0)
               && (cfg_nbuf_i != '0)
               && (cfg_nbuf_i <= NB_W'(MAX_BUF));
  assign go     = idle && start_i && cfg_ok;
  assign bad    = idle && start_i && !cfg_ok;

  // Load lengths come from the live inputs only at the start edge.
  assign u_hres   = idle ? cfg_hres_i : sh_hres;
  assign u_hblank = idle ? cfg_hblank_i : sh_hblank;
  assign u_vs     = idle ? cfg_vsync_lines_i : sh_vs;
  assign vs_n     = (u_vs == 8'd0) ? 8'd1 : u_vs;

  assign lp      = CNT_W'(u_hres) + CNT_W'(u_hres) + CNT_W'(u_hblank);
  assign vs_len  = CNT_W'(vs_n) * lp;
  assign vbp_len = CNT_W'(sh_vbp) * lp;
  assign vfp_len = (sh_vfp == 8'd0) ? CNT_W'(1) : CNT_W'(sh_vfp) * lp;
  assign act_len = CNT_W'(sh_hres) + CNT_W'(sh_hres);

  assign tmr_last  = (tmr_q == CNT_W'(1));
  assign line_last = (line_o == sh_vres - PTR_W'(1));
  assign col_last  = bytesel_o && (col_o == sh_hres - PTR_W'(1));
  assign vfp_end   = (state_q == S_VFP) && tmr_last;
  assign fr_next   = frm_q + 16'd1;
  assign end_seq   = stop_q || ((sh_nfr != 16'd0) && (fr_next == sh_nfr));
  assign nb_inc    = NB_W'(bufsel_o) + NB_W'(1);

  // State, timer, shadow config, stop flag and frame counter.
  always_ff @(posedge cam_clk_o or negedge s_rstn) begin
    if (!s_rstn) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      sh_hres   <= '0;
      sh_vres   <= '0;
      sh_hblank <= '0;
      sh_vs     <= '0;
      sh_vbp    <= '0;
      sh_vfp    <= '0;
      sh_nfr    <= '0;
      sh_nbuf   <= '0;
      stop_q    <= 1'b0;
      frm_q     <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if (go) begin
        sh_hres   <= cfg_hres_i;
        sh_vres   <= cfg_vres_i;
        sh_hblank <= cfg_hblank_i;
        sh_vs     <= cfg_vsync_lines_i;
        sh_vbp    <= cfg_vbp_lines_i;
        sh_vfp    <= cfg_vfp_lines_i;
        sh_nfr    <= cfg_nframes_i;
        sh_nbuf   <= cfg_nbuf_i;
      end
      if (idle) begin
        stop_q <= go && stop_i;
        frm_q  <= '0;
      end else if (vfp_end) begin
        stop_q <= end_seq ? 1'b0 : (stop_q | stop_i);
        frm_q  <= end_seq ? '0 : fr_next;
      end else if (stop_i) begin
        stop_q <= 1'b1;
      end
    end
  end

  // Next state and timer reload on every state entry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q - CNT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (go) begin
          state_d = S_VSYNC;
          tmr_d   = vs_len;
        end
      end
      S_VSYNC: begin
        if (tmr_last) begin
          if (sh_vbp != 8'd0) begin
            state_d = S_VBP;
            tmr_d   = vbp_len;
          end else begin
            state_d = S_ACTIVE;
            tmr_d   = act_len;
          end
        end
      end
      S_VBP: begin
        if (tmr_last) begin
          state_d = S_ACTIVE;
          tmr_d   = act_len;
        end
      end
      S_ACTIVE: begin
        if (tmr_last) begin
          if (line_last) begin
            state_d = S_VFP;
            tmr_d   = vfp_len;
          end else if (sh_hblank != '0) begin
            state_d = S_HBLANK;
            tmr_d   = CNT_W'(sh_hblank);
          end else begin
            state_d = S_ACTIVE;
            tmr_d   = act_len;
          end
        end
      end
      S_HBLANK: begin
        if (tmr_last) begin
          state_d = S_ACTIVE;
          tmr_d   = act_len;
        end
      end
      S_VFP: begin
        if (tmr_last) begin
          if (end_seq) begin
            state_d = S_IDLE;
            tmr_d   = '0;
          end else begin
            state_d = S_VSYNC;
            tmr_d   = vs_len;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE);
    bsel_d  = bytesel_o;
    col_d   = col_o;
    line_d  = line_o;
    addr_d  = pix_addr_o;
    buf_d   = bufsel_o;
    fdone_d = 1'b0;
    sdone_d = 1'b0;
    err_d   = bad;
    unique case (1'b1)
      (state_q == S_ACTIVE): begin
        bsel_d = ~bytesel_o;
        if (bytesel_o) begin
          if (col_last) begin
            col_d = '0;
            if (line_last) begin
              line_d = '0;
              addr_d = '0;
            end else begin
              line_d = line_o + PTR_W'(1);
              addr_d = pix_addr_o + CNT_W'(1);
            end
          end else begin
            col_d  = col_o + PTR_W'(1);
            addr_d = pix_addr_o + CNT_W'(1);
          end
        end
      end
      (state_q == S_HBLANK): begin
      end
      vfp_end: begin
        fdone_d = 1'b1;
        buf_d   = (nb_inc >= sh_nbuf) ? '0 : bufsel_o + BUF_W'(1);
        if (end_seq) begin
          sdone_d = 1'b1;
          buf_d   = '0;
        end
      end
      default: begin
        bsel_d = 1'b0;
        col_d  = '0;
        line_d = '0;
        addr_d = '0;
        if (idle) buf_d = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge cam_clk_o or negedge s_rstn) begin
    if (!s_rstn) begin
      busy_o       <= 1'b0;
      vsync_o      <= 1'b0;
      href_o       <= 1'b0;
      bytesel_o    <= 1'b0;
      col_o        <= '0;
      line_o       <= '0;
      pix_addr_o   <= '0;
      bufsel_o     <= '0;
      frame_done_o <= 1'b0;
      seq_done_o   <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      busy_o       <= busy_d;
      vsync_o      <= vsync_d;
      href_o       <= href_d;
      bytesel_o    <= bsel_d;
      col_o        <= col_d;
      line_o       <= line_d;
      pix_addr_o   <= addr_d;
      bufsel_o     <= buf_d;
      frame_done_o <= fdone_d;
      seq_done_o   <= sdone_d;
      err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_cam_vip_seq_ctrl.sv
// Bench for cam_vip_seq_ctrl: per-cycle output trace compared
// against a frame-structure model built from the configuration.
module tb_cam_vip_seq_ctrl;

  typedef logic [72:0] vec_t;

  logic        clk = 1'b0;
  logic        s_rstn;
  logic        start_i, stop_i;
  logic [15:0] cfg_hres_i, cfg_vres_i, cfg_hblank_i;
  logic [7:0]  cfg_vsync_lines_i, cfg_vbp_lines_i, cfg_vfp_lines_i;
  logic [15:0] cfg_nframes_i;
  logic [2:0]  cfg_nbuf_i;
  logic        busy_o, vsync_o, href_o, bytesel_o;
  logic [15:0] col_o, line_o;
  logic [31:0] pix_addr_o;
  logic [1:0]  bufsel_o;
  logic        frame_done_o, seq_done_o, err_o;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  int mark_stop, mark_col2;

  always #5 clk = ~clk;

  cam_vip_seq_ctrl dut (
    .cam_clk_o(clk), .s_rstn(s_rstn),
    .start_i(start_i), .stop_i(stop_i),
    .cfg_hres_i(cfg_hres_i), .cfg_vres_i(cfg_vres_i),
    .cfg_hblank_i(cfg_hblank_i),
    .cfg_vsync_lines_i(cfg_vsync_lines_i),
    .cfg_vbp_lines_i(cfg_vbp_lines_i),
    .cfg_vfp_lines_i(cfg_vfp_lines_i),
    .cfg_nframes_i(cfg_nframes_i), .cfg_nbuf_i(cfg_nbuf_i),
    .busy_o(busy_o), .vsync_o(vsync_o), .href_o(href_o),
    .bytesel_o(bytesel_o), .col_o(col_o), .line_o(line_o),
    .pix_addr_o(pix_addr_o), .bufsel_o(bufsel_o),
    .frame_done_o(frame_done_o), .seq_done_o(seq_done_o),
    .err_o(err_o)
  );

  function automatic vec_t pk(int bz, int vs, int hr, int bs,
                              int c, int l, int a, int b,
                              int fd, int sd, int er);
    logic [31:0] cc, ll, aa, bb;
    cc = c; ll = l; aa = a; bb = b;
    return {bz[0], vs[0], hr[0], bs[0], cc[15:0], ll[15:0],
            aa, bb[1:0], fd[0], sd[0], er[0]};
  endfunction

  function automatic vec_t dut_v();
    return {busy_o, vsync_o, href_o, bytesel_o, col_o, line_o,
            pix_addr_o, bufsel_o, frame_done_o, seq_done_o, err_o};
  endfunction

  task automatic chk(string tag, vec_t got, vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Whole-sequence trace: one entry per cycle starting at the
  // first cycle after the start edge, ending with the done cycle
  // and one quiet idle cycle.
  task automatic build(int h, int v, int hb, int vs, int vbp,
                       int vfp, int nf, int nb);
    int lp, b, fd, nvfp;
    exp_q.delete();
    mark_stop = -1;
    mark_col2 = -1;
    lp = 2 * h + hb;
    b = 0;
    fd = 0;
    if (vs == 0) vs = 1;
    nvfp = (vfp == 0) ? 1 : vfp * lp;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < vs * lp; i++) begin
        exp_q.push_back(pk(1, 1, 0, 0, 0, 0, 0, b, fd, 0, 0));
        fd = 0;
      end
      for (int i = 0; i < vbp * lp; i++)
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, b, 0, 0, 0));
      for (int l = 0; l < v; l++) begin
        for (int k = 0; k < 2 * h; k++) begin
          if (f == 1 && l == 1 && k == 0) mark_stop = exp_q.size();
          if (f == 0 && l == 0 && k == 4) mark_col2 = exp_q.size();
          exp_q.push_back(pk(1, 0, 1, k % 2, k / 2, l,
                             l * h + k / 2, b, 0, 0, 0));
        end
        if (l < v - 1)
          for (int i = 0; i < hb; i++)
            exp_q.push_back(pk(1, 0, 0, 0, 0, l + 1,
                               (l + 1) * h, b, 0, 0, 0));
      end
      for (int i = 0; i < nvfp; i++)
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, b, 0, 0, 0));
      b = (b + 1) % nb;
      fd = 1;
    end
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    exp_q.push_back('0);
  endtask

  task automatic setcfg(int h, int v, int hb, int vs, int vbp,
                        int vfp, int nfr, int nb);
    cfg_hres_i        = 16'(h);
    cfg_vres_i        = 16'(v);
    cfg_hblank_i      = 16'(hb);
    cfg_vsync_lines_i = 8'(vs);
    cfg_vbp_lines_i   = 8'(vbp);
    cfg_vfp_lines_i   = 8'(vfp);
    cfg_nframes_i     = 16'(nfr);
    cfg_nbuf_i        = 3'(nb);
  endtask

  task automatic run_seq(string tag, int stop_at, int rst_at,
                         bit chg, bit ss);
    @(negedge clk);
    start_i = 1'b1;
    stop_i  = ss;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(tag, dut_v(), exp_q[i]);
      if (i == rst_at) begin
        s_rstn = 1'b0;
        #1;
        chk("rst_async", dut_v(), '0);
        break;
      end
      stop_i  = (i == stop_at);
      start_i = chg && (i == 7);
      if (chg && i == 5) cfg_hres_i = 16'd8;
      @(negedge clk);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic bad_start(string tag);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk(tag, dut_v(), pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk({tag, "_idle"}, dut_v(), '0);
  endtask

  initial begin
    int h, v, hb, vs, vbp, vfp, nfr, nb;
    s_rstn  = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    setcfg(4, 2, 3, 1, 1, 1, 1, 2);
    repeat (2) @(negedge clk);
    chk("reset", dut_v(), '0);
    s_rstn = 1'b1;
    @(negedge clk);
    chk("idle", dut_v(), '0);

    // Base timing, LP = 11.
    build(4, 2, 3, 1, 1, 1, 1, 2);
    run_seq("base", -1, -1, 1'b0, 1'b0);

    // Rotation with back-to-back lines.
    setcfg(3, 2, 0, 1, 1, 1, 5, 3);
    build(3, 2, 0, 1, 1, 1, 5, 3);
    run_seq("rot", -1, -1, 1'b0, 1'b0);

    // Continuous mode, stop during line 1 of frame 2.
    setcfg(4, 3, 2, 1, 0, 0, 0, 4);
    build(4, 3, 2, 1, 0, 0, 2, 4);
    run_seq("stop", mark_stop, -1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("stop_quiet", dut_v(), '0);
    end

    // Start and stop together: one frame.
    setcfg(2, 1, 1, 0, 1, 0, 0, 2);
    build(2, 1, 1, 0, 1, 0, 1, 2);
    run_seq("startstop", -1, -1, 1'b0, 1'b1);

    // Rejected starts.
    setcfg(0, 2, 3, 1, 1, 1, 1, 2);
    bad_start("err_hres");
    setcfg(4, 2, 3, 1, 1, 1, 1, 5);
    bad_start("err_nbuf");
    setcfg(4, 0, 3, 1, 1, 1, 1, 2);
    bad_start("err_vres");

    // Reset mid-ACTIVE at col 2, then a clean frame.
    setcfg(4, 2, 3, 1, 1, 1, 2, 2);
    build(4, 2, 3, 1, 1, 1, 2, 2);
    run_seq("pre_rst", -1, mark_col2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_hold", dut_v(), '0);
    s_rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_idle", dut_v(), '0);
    end
    setcfg(4, 2, 3, 1, 1, 1, 1, 2);
    build(4, 2, 3, 1, 1, 1, 1, 2);
    run_seq("post_rst", -1, -1, 1'b0, 1'b0);

    // Config change and stray start while busy.
    setcfg(4, 2, 1, 1, 1, 1, 2, 2);
    build(4, 2, 1, 1, 1, 1, 2, 2);
    run_seq("cfgchg", -1, -1, 1'b1, 1'b0);

    // Randomized configurations.
    for (int n = 0; n < 10; n++) begin
      h   = $urandom_range(1, 5);
      v   = $urandom_range(1, 3);
      hb  = $urandom_range(0, 3);
      vs  = $urandom_range(0, 2);
      vbp = $urandom_range(0, 2);
      vfp = $urandom_range(0, 2);
      nfr = $urandom_range(1, 3);
      nb  = $urandom_range(1, 4);
      setcfg(h, v, hb, vs, vbp, vfp, nfr, nb);
      build(h, v, hb, vs, vbp, vfp, nfr, nb);
      run_seq("rand", -1, -1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_vip_seq_ctrl.md
Name: cam_vip_seq_ctrl

Overview:
Programmable timing sequencer for the camera VIP pixel datapath. It generates vsync/href framing, byte select, column/line pointers, the flat pixel address and the frame-buffer select that index the preloaded RGB565 frame stores. It replaces fixed blanking constants with runtime configuration. It supports start/stop handshakes, a frame count limit, and round-robin selection over up to 4 frame buffers.

Parameters:
CNT_W, 32, width of the blanking/timer counter and of pix_addr_o
PTR_W, 16, width of the column/line pointers and the resolution fields
MAX_BUF, 4, maximum number of frame buffers; bufsel_o width is clog2(MAX_BUF)

Ports:
cam_clk_o  in  1  pixel clock; all logic on the rising edge
s_rstn  in  1  async active-low reset
start_i  in  1  start sequence; sampled in IDLE only
stop_i  in  1  request graceful stop at end of current frame
cfg_hres_i  in  PTR_W  pixels per line
cfg_vres_i  in  PTR_W  lines per frame
cfg_hblank_i  in  PTR_W  href-low cycles between active lines
cfg_vsync_lines_i  in  8  vsync width in line periods (0 treated as 1)
cfg_vbp_lines_i  in  8  back porch in line periods
cfg_vfp_lines_i  in  8  front porch in line periods
cfg_nframes_i  in  16  frames to send; 0 = continuous
cfg_nbuf_i  in  clog2(MAX_BUF)+1  buffers in rotation, 1..MAX_BUF
busy_o  out  1  high while state != IDLE
vsync_o  out  1  frame sync
href_o  out  1  line valid
bytesel_o  out  1  0 = high RGB565 byte, 1 = low byte
col_o  out  PTR_W  current column
line_o  out  PTR_W  current line
pix_addr_o  out  CNT_W  line_o*hres + col_o
bufsel_o  out  clog2(MAX_BUF)  current frame buffer
frame_done_o  out  1  1-cycle pulse at end of each frame
seq_done_o  out  1  1-cycle pulse on return to IDLE
err_o  out  1  1-cycle pulse on rejected start

Behaviour:
- Clock and reset: cam_clk_o, with s_rstn as an asynchronous active-low reset. On reset, state = IDLE and every output is 0. The stop flag, frame counter and shadow config are cleared.
- Timing unit: line period LP = 2*hres + hblank cycles, computed from the shadow config.
- start_i in IDLE: if hres==0, vres==0, nbuf==0 or nbuf>MAX_BUF, pulse err_o on the next cycle and stay in IDLE. Otherwise latch all cfg_* into shadow registers and enter VSYNC on the next cycle. start_i outside IDLE is ignored. cfg_* changes while busy have no effect.
- All outputs are registered; there is no combinational input-to-output path.
- States:
  - IDLE: all framing outputs 0.
  - VSYNC: vsync_o=1 for max(vsync_lines,1)*LP cycles, then go to VBP.
  - VBP: vsync_o=0 for vbp_lines*LP cycles. If the count is 0, skip straight to ACTIVE. col and line are set to 0 on entry to ACTIVE.
  - ACTIVE: href_o=1 for 2*hres cycles. bytesel_o starts at 0 and toggles every cycle. col increments on cycles where bytesel_o=1. At col=hres-1 with bytesel_o=1, col wraps to 0. If line=vres-1, line goes to 0 and the next state is VFP. Otherwise line increments and the next state is HBLANK, or ACTIVE directly when hblank==0 (href stays high continuously).
  - HBLANK: href_o=0 for hblank cycles; col, line and bytesel hold. Then go to ACTIVE.
  - VFP: vfp_lines*LP cycles (0 = a single transition cycle). On the final cycle:
    - pulse frame_done_o;
    - increment the frame count;
    - advance bufsel_o modulo nbuf;
    - if the stop flag is set or count==nframes (nframes!=0), go to IDLE with a seq_done_o pulse the same cycle and bufsel_o returning to 0;
    - otherwise go to VSYNC.
- stop_i while busy sets a sticky stop flag, which is honoured only at the end of VFP; the current frame always completes. stop_i in IDLE is ignored. If start_i and stop_i are asserted together in IDLE, start wins and the flag is set, so exactly 1 frame is sent.
- pix_addr_o = line*hres + col, computed in CNT_W with no truncation for hres*vres < 2^CNT_W. It is updated in the same cycle as col_o and line_o.
- Timer: a CNT_W down-counter loaded on each state entry. A state's exit occurs on the cycle after the counter reaches 1.
- Reset mid-frame: outputs drop to 0 asynchronously. After release the block remains in IDLE until a new start_i.

Test Plan:
- Base timing, with hres=4, vres=2, hblank=3, vsync=1, vbp=1, vfp=1, nframes=1, nbuf=2, LP=11 → required response:
  - vsync_o high 11 cycles, then low 11 cycles;
  - href_o high 8 / low 3 / high 8;
  - bytesel_o toggles 0,1,…, col_o sequence 0,0,1,1,2,2,3,3, pix_addr_o 0..7;
  - 11 VFP cycles, then frame_done_o and seq_done_o pulse together; busy_o low after.
- Rotation, with nframes=5, nbuf=3, hblank=0 → bufsel_o per frame is 0,1,2,0,1; href_o stays high 2*hres*vres contiguous cycles per frame; 5 frame_done_o pulses, 1 seq_done_o.
- Graceful stop, with nframes=0: assert stop_i during line 1 of frame 2 → frame 2 completes, then frame_done_o and seq_done_o pulse; no further vsync_o.
- Invalid config, start_i with hres=0, then with nbuf=5 → err_o pulses once per attempt; busy_o stays 0; vsync_o never asserts.
- Reset mid-ACTIVE: drop s_rstn at col=2 → all outputs 0 immediately; after release, nothing happens without start_i. A new start_i yields bufsel_o=0 and a full frame.
- Config change while busy: change cfg_hres_i from 4 to 8 mid-frame → the current and following frames still use hres=4 until return to IDLE.
